// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a word-indexed pc into a registered-read instruction
// memory and presents fetched instructions to decode, with stall skid, redirect and fault handling.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned PC_INC    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  input  logic [31:0] mem_instruction,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        fault
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, FAULT} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx;
  logic [31:0] pc_d1, pc_d1_nx;
  logic        vld_d1, vld_d1_nx;
  logic [31:0] skid, skid_nx;
  logic        fault_nx;

  logic [32:0] seq_pc;
  logic        seq_oob;
  logic        redir_oob;
  logic        drained;

  // 33-bit arithmetic so the end of memory is detected instead of silently wrapping
  assign seq_pc    = {1'b0, pc} + 33'(PC_INC);
  assign seq_oob   = seq_pc >= 33'(MEM_DEPTH);
  assign redir_oob = {1'b0, redirect_pc} >= 33'(MEM_DEPTH);
  // The last legal pc has already been handed to decode; only then is it time to fault
  assign drained   = vld_d1 && (pc_d1 == pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      pc_d1  <= '0;
      vld_d1 <= 1'b0;
      skid   <= '0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      pc_d1  <= pc_d1_nx;
      vld_d1 <= vld_d1_nx;
      skid   <= skid_nx;
      fault  <= fault_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    pc_d1_nx  = pc_d1;
    vld_d1_nx = vld_d1;
    skid_nx   = skid;
    fault_nx  = fault;
    unique case (state)
      BOOT: state_nx = RUN;
      RUN, HOLD: begin
        if (redirect) begin
          vld_d1_nx = 1'b0;
          if (redir_oob) begin
            fault_nx = 1'b1;
            state_nx = FAULT;
          end else begin
            pc_nx    = redirect_pc;
            state_nx = RUN;
          end
        end else if (stall) begin
          // Only a valid instruction needs saving; the memory output moves on next cycle
          if (state == RUN && vld_d1) begin
            skid_nx  = mem_instruction;
            state_nx = HOLD;
          end
        end else begin
          state_nx = RUN;
          if (!seq_oob) begin
            pc_nx     = seq_pc[31:0];
            pc_d1_nx  = pc;
            vld_d1_nx = 1'b1;
          end else if (drained) begin
            vld_d1_nx = 1'b0;
            fault_nx  = 1'b1;
            state_nx  = FAULT;
          end else begin
            pc_d1_nx  = pc;
            vld_d1_nx = 1'b1;
          end
        end
      end
      FAULT: state_nx = FAULT;
      default: state_nx = BOOT;
    endcase
  end

  assign if_pc    = pc_d1;
  assign if_valid = vld_d1;
  assign if_instr = (state == HOLD) ? skid : mem_instruction;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 0: word index presented to instr_mem after reset.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 1024: instr_mem depth in words; legal fetch indices are 0..MEM_DEPTH-1.
REQ-003 The block SHALL have parameter PC_INC, default 1: sequential increment of the word-indexed PC.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 The clock port SHALL be: clk  in  1  single clock, rising edge.
REQ-006 The reset port SHALL be: reset  in  1  synchronous, active-high.
REQ-007 The stall port SHALL be: stall  in  1  downstream not ready; hold the current fetch output.
REQ-008 The redirect port SHALL be: redirect  in  1  branch/jump taken; refetch from redirect_pc.
REQ-009 The redirect_pc port SHALL be: redirect_pc  in  32  target word index.
REQ-010 The mem_pc port SHALL be: pc  out  32  address driven to instr_mem.pc.
REQ-011 The mem_instruction port SHALL be: mem_instruction  in  32  instr_mem.instruction, valid one cycle after pc (registered read).
REQ-012 The if_instr port SHALL be: if_instr  out  32  fetched instruction to decode.
REQ-013 The if_pc port SHALL be: if_pc  out  32  word index of if_instr.
REQ-014 The if_valid port SHALL be: if_valid  out  1  if_instr/if_pc meaningful this cycle.
REQ-015 The fault port SHALL be: fault  out  1  sticky; fetch address out of range.

Function
REQ-016 The FSM SHALL have states BOOT, RUN, HOLD and FAULT; state SHALL be BOOT on reset.
REQ-017 BOOT SHALL last exactly one cycle with pc=RESET_PC and if_valid=0, then go to RUN.
REQ-018 In RUN without stall or redirect, pc SHALL advance by PC_INC each cycle; in-flight tag pc_d1 <= pc and vld_d1 <= 1.
REQ-019 Fetch latency SHALL be 1 cycle: if_pc=pc_d1, if_valid=vld_d1, and if_instr=mem_instruction in RUN.
REQ-020 On a stall with if_valid=1 in RUN, mem_instruction SHALL be captured into the skid register, pc and pc_d1 SHALL be held, and the FSM SHALL go to HOLD.
REQ-021 In HOLD, if_instr SHALL come from the skid register and if_pc/if_valid SHALL be unchanged, for every stalled cycle.
REQ-022 When stall drops in HOLD, the held instruction SHALL be consumed that cycle; pc SHALL advance, and next cycle if_pc SHALL equal the held pc + PC_INC with no duplicate and no gap; FSM -> RUN.
REQ-023 A stall with if_valid=0 SHALL only freeze pc; no skid capture SHALL occur.
REQ-024 Redirect SHALL have priority over stall in RUN and HOLD: pc <= redirect_pc, vld_d1 <= 0 (in-flight squashed), FSM -> RUN.
REQ-025 The cycle after a redirect SHALL have if_valid=0; the cycle after that SHALL have if_pc=redirect_pc, if_valid=1.
REQ-026 If a computed next pc (sequential or redirect_pc) is >= MEM_DEPTH, fault SHALL be set, FSM -> FAULT, and pc SHALL be held at its last legal value.
REQ-027 In FAULT, if_valid SHALL be 0, and all inputs except reset SHALL be ignored until reset.
REQ-028 Sequential arithmetic SHALL be 32-bit unsigned with no wrap-around; reaching MEM_DEPTH is a fault, not a wrap.
REQ-029 If redirect and stall are both asserted in FAULT, FAULT SHALL have priority and the inputs SHALL be ignored.

Reset
REQ-030 Synchronous reset SHALL force pc=RESET_PC, pc_d1=0, vld_d1=0, skid=0, if_valid=0, if_pc=0, fault=0 and state=BOOT, overriding all inputs.
REQ-031 Reset asserted mid-HOLD or mid-FAULT SHALL discard the skid contents and any pending redirect; no instruction SHALL be presented until 2 cycles after reset deasserts.
REQ-032 Outputs SHALL be deterministic from the first clk edge with reset high; no X SHALL be present on if_valid or fault.

Verification
REQ-033 Sequential fetch: mem preloaded mem[i]=i+0x100; release reset -> if_valid first 1 on cycle 2 with if_pc=0, if_instr=0x100, then if_pc=1,2,3 on consecutive cycles.
REQ-034 Stall for 3 cycles while if_pc=5 -> if_pc=5, if_instr=0x105 and if_valid=1 held for all 3 cycles; after release, next if_pc=6 with 0x106.
REQ-035 Redirect to 20 while if_pc=7 -> one cycle if_valid=0, then if_pc=20, if_instr=0x114; in-flight pc 8 is never presented.
REQ-036 Redirect and stall asserted together in HOLD -> redirect wins, skid is dropped, and if_pc=redirect_pc appears 2 cycles later.
REQ-037 Redirect to 1024 with MEM_DEPTH=1024 -> fault=1 the next cycle and if_valid=0 thereafter, with stall/redirect ignored; reset clears fault and fetch restarts at RESET_PC.
REQ-038 Sequential run to 1023 -> if_pc=1023 is presented, then fault=1 with no wrap to 0.
